// File: rtl/game_score_ctrl_pkg.sv
// ============================================================================
// Module : flappy_pkg
// Brief  : Game-flow state encoding and score width shared by game blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flappy_pkg;

  localparam int c_SCORE_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_LOST = 2'd2
  } game_state_e;

endpackage

`default_nettype wire

// File: rtl/game_score_ctrl_if.sv
// ============================================================================
// Module : game_score_if
// Brief  : Button/event inputs and score/status outputs of the game controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface game_score_if #(
  parameter int SCORE_W = flappy_pkg::c_SCORE_W
);
  logic               btn_start;
  logic               pipe_passed;
  logic               collision;
  logic               game_state;
  logic               lost;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               new_record;

  modport master (
    output btn_start, pipe_passed, collision,
    input  game_state, lost, score, high_score, new_record
  );

  modport slave (
    input  btn_start, pipe_passed, collision,
    output game_state, lost, score, high_score, new_record
  );
endinterface

`default_nettype wire

// File: rtl/game_score_ctrl_btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : 2-FF synchronizer, debounce counter and one-cycle rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  btn,
  output logic start_pulse
);

  localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]         r_sync;
  logic               r_prev;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b00;
      r_prev      <= 1'b0;
      r_cnt       <= '0;
      r_level     <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], btn};
      r_prev      <= r_sync[1];
      start_pulse <= 1'b0;
      // Any change of the synced level restarts the stability window.
      if (r_sync[1] != r_prev) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_level != r_prev) begin
        r_level     <= r_prev;
        start_pulse <= r_prev;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_score_ctrl.sv
// ============================================================================
// Module : game_score_ctrl
// Brief  : IDLE/PLAY/LOST game FSM, saturating score and restart lockout.
//          Optional high-score tracking enabled by macro HIGH_SCORE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_score_ctrl
  import flappy_pkg::*;
#(
  parameter int SCORE_W         = c_SCORE_W,
  parameter int SCORE_MAX       = 2047,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LOCKOUT_CYCLES  = 100_000_000
) (
  input wire           clk,
  input wire           rst_n,
  game_score_if.slave  bus
);

  localparam int                  c_LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [c_LOCK_W-1:0] c_LOCK_MAX  = c_LOCK_W'(LOCKOUT_CYCLES);
  localparam logic [SCORE_W-1:0]  c_SCORE_MAX = SCORE_W'(SCORE_MAX);

  logic                w_start_pulse;
  logic                w_restart;
  game_state_e         r_state;
  logic [SCORE_W-1:0]  r_score;
  logic [c_LOCK_W-1:0] r_lock_cnt;
  logic                r_game_state;
  logic                r_lost;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (bus.btn_start),
    .start_pulse (w_start_pulse)
  );

  assign w_restart = (r_state == ST_LOST) && (r_lock_cnt == c_LOCK_MAX) && w_start_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_score      <= '0;
      r_lock_cnt   <= '0;
      r_game_state <= 1'b0;
      r_lost       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_pulse) begin
            r_state      <= ST_PLAY;
            r_game_state <= 1'b1;
            r_score      <= '0;
          end
        end
        ST_PLAY: begin
          if (bus.collision) begin
            r_state      <= ST_LOST;
            r_game_state <= 1'b0;
            r_lost       <= 1'b1;
            r_lock_cnt   <= '0;
          end else if (bus.pipe_passed && (r_score != c_SCORE_MAX)) begin
            r_score <= r_score + 1'b1;
          end
        end
        ST_LOST: begin
          // Presses arriving while the lockout is still running are dropped.
          if (r_lock_cnt != c_LOCK_MAX) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end else if (w_start_pulse) begin
            r_state      <= ST_PLAY;
            r_game_state <= 1'b1;
            r_lost       <= 1'b0;
            r_score      <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.game_state = r_game_state;
  assign bus.lost       = r_lost;
  assign bus.score      = r_score;

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_high_score;
  logic               r_new_record;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_score <= '0;
      r_new_record <= 1'b0;
    end else if ((r_state == ST_PLAY) && bus.collision && (r_score > r_high_score)) begin
      r_high_score <= r_score;
      r_new_record <= 1'b1;
    end else if (w_restart) begin
      r_new_record <= 1'b0;
    end
  end

  assign bus.high_score = r_high_score;
  assign bus.new_record = r_new_record;
`else
  assign bus.high_score = '0;
  assign bus.new_record = 1'b0;
`endif

endmodule

`default_nettype wire
